// File: rtl/vm2002_change_dispenser_if.sv
// Change-dispenser bus: payout request/result, coin-release handshake,
// tube refill channel and tube-count observation.
//  master : the dispenser (drives busy, coin_*, done, shortfall, errors, counts)
//  slave  : the environment (vm2002 FSM, coin mechanism, supplier)
interface vm2002_change_dispenser_if #(
  parameter int unsigned AMT_W  = 16,
  parameter int unsigned TUBE_W = 6
);
  logic              start;
  logic [AMT_W-1:0]  balance;
  logic              busy;
  logic              coin_valid;
  logic [1:0]        coin_code;
  logic              coin_ack;
  logic              done;
  logic [AMT_W-1:0]  shortfall;
  logic              short_err;
  logic              jam_err;
  logic              refill_valid;
  logic [1:0]        refill_coin;
  logic [TUBE_W-1:0] refill_count;
  logic              refill_ovf;
  logic [TUBE_W-1:0] n_cnt;
  logic [TUBE_W-1:0] d_cnt;
  logic [TUBE_W-1:0] q_cnt;

  modport master (
    input  start, balance, coin_ack, refill_valid, refill_coin, refill_count,
    output busy, coin_valid, coin_code, done, shortfall, short_err, jam_err,
           refill_ovf, n_cnt, d_cnt, q_cnt
  );

  modport slave (
    output start, balance, coin_ack, refill_valid, refill_coin, refill_count,
    input  busy, coin_valid, coin_code, done, shortfall, short_err, jam_err,
           refill_ovf, n_cnt, d_cnt, q_cnt
  );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Change dispenser: pays out a balance as coins, greedy quarter > dime > nickel,
// against finite tubes. One coin per valid/ack handshake; an ack timeout aborts
// the payout as a jam. Reports unpaid remainder as shortfall.
// Ports:
//  clk     system clock, rising edge
//  hrst_n  asynchronous active-low reset
//  bus     vm2002_change_dispenser_if.master (start/balance, coin handshake,
//          done/shortfall/errors, refill channel, tube counts)
module vm2002_change_dispenser #(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned TUBE_W      = 6,
  parameter int unsigned TUBE_MAX    = 50,
  parameter int unsigned INIT_CNT    = 10,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        hrst_n,
  vm2002_change_dispenser_if.master   bus
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_e;
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00, NICKEL = 2'b01, DIME = 2'b10, QUARTER = 2'b11
  } coin_e;

  state_e            state_q;
  coin_e             coin_code_q;
  logic [AMT_W-1:0]  remain_q, shortfall_q;
  logic [TMR_W-1:0]  timer_q;
  logic              busy_q, coin_valid_q, done_q;
  logic              short_err_q, jam_err_q, refill_ovf_q;
  logic [TUBE_W-1:0] n_q, d_q, q_q;

  coin_e             sel_code_d;
  logic [AMT_W-1:0]  issue_val_d;
  logic [TUBE_W-1:0] refill_cur_d, refill_new_d;
  logic [TUBE_W:0]   refill_sum_d;
  logic              refill_clip_d;

  always_comb begin
    sel_code_d = COIN_NONE;
    if (remain_q >= AMT_W'(25) && q_q != '0)      sel_code_d = QUARTER;
    else if (remain_q >= AMT_W'(10) && d_q != '0) sel_code_d = DIME;
    else if (remain_q >= AMT_W'(5) && n_q != '0)  sel_code_d = NICKEL;

    issue_val_d = '0;
    case (coin_code_q)
      QUARTER: issue_val_d = AMT_W'(25);
      DIME:    issue_val_d = AMT_W'(10);
      NICKEL:  issue_val_d = AMT_W'(5);
      default: issue_val_d = '0;
    endcase

    refill_cur_d = '0;
    case (bus.refill_coin)
      2'b01:   refill_cur_d = n_q;
      2'b10:   refill_cur_d = d_q;
      2'b11:   refill_cur_d = q_q;
      default: refill_cur_d = '0;
    endcase
    // One extra bit so the sum cannot wrap before the saturation test.
    refill_sum_d  = {1'b0, refill_cur_d} + {1'b0, bus.refill_count};
    refill_clip_d = refill_sum_d > (TUBE_W+1)'(TUBE_MAX);
    refill_new_d  = refill_clip_d ? TUBE_W'(TUBE_MAX) : refill_sum_d[TUBE_W-1:0];
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q      <= IDLE;
      coin_code_q  <= COIN_NONE;
      remain_q     <= '0;
      shortfall_q  <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      short_err_q  <= 1'b0;
      jam_err_q    <= 1'b0;
      refill_ovf_q <= 1'b0;
      n_q          <= TUBE_W'(INIT_CNT);
      d_q          <= TUBE_W'(INIT_CNT);
      q_q          <= TUBE_W'(INIT_CNT);
    end else begin
      done_q       <= 1'b0;
      refill_ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            remain_q    <= bus.balance;
            shortfall_q <= '0;
            short_err_q <= 1'b0;
            jam_err_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SELECT;
          end else if (bus.refill_valid && bus.refill_coin != 2'b00) begin
            refill_ovf_q <= refill_clip_d;
            case (bus.refill_coin)
              2'b01:   n_q <= refill_new_d;
              2'b10:   d_q <= refill_new_d;
              default: q_q <= refill_new_d;
            endcase
          end
        end
        SELECT: begin
          if (sel_code_d != COIN_NONE) begin
            coin_code_q  <= sel_code_d;
            coin_valid_q <= 1'b1;
            timer_q      <= '0;
            state_q      <= ISSUE;
          end else begin
            // done/shortfall are registered on entry so they show during FINISH.
            done_q      <= 1'b1;
            shortfall_q <= remain_q;
            short_err_q <= (remain_q != '0);
            state_q     <= FINISH;
          end
        end
        ISSUE: begin
          // Ack is tested first so an ack in the timeout cycle still pays the coin.
          if (bus.coin_ack) begin
            case (coin_code_q)
              QUARTER: if (q_q != '0) q_q <= q_q - 1'b1;
              DIME:    if (d_q != '0) d_q <= d_q - 1'b1;
              NICKEL:  if (n_q != '0) n_q <= n_q - 1'b1;
              default: ;
            endcase
            remain_q     <= remain_q - issue_val_d;
            coin_valid_q <= 1'b0;
            coin_code_q  <= COIN_NONE;
            state_q      <= SELECT;
          end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
            jam_err_q    <= 1'b1;
            coin_valid_q <= 1'b0;
            coin_code_q  <= COIN_NONE;
            done_q       <= 1'b1;
            shortfall_q  <= remain_q;
            short_err_q  <= (remain_q != '0);
            state_q      <= FINISH;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_code  = coin_code_q;
  assign bus.done       = done_q;
  assign bus.shortfall  = shortfall_q;
  assign bus.short_err  = short_err_q;
  assign bus.jam_err    = jam_err_q;
  assign bus.refill_ovf = refill_ovf_q;
  assign bus.n_cnt      = n_q;
  assign bus.d_cnt      = d_q;
  assign bus.q_cnt      = q_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for vm2002_change_dispenser: stimulus predicts coins and
// payout results with an arithmetic greedy model; a monitor pops and compares.
module tb_vm2002_change_dispenser;
  localparam int AMT_W = 16, TUBE_W = 6, TUBE_MAX = 50, INIT_CNT = 10, ACK_TIMEOUT = 8;

  logic clk = 1'b0;
  logic hrst_n;
  always #5 clk = ~clk;

  vm2002_change_dispenser_if #(.AMT_W(AMT_W), .TUBE_W(TUBE_W)) bus ();

  vm2002_change_dispenser #(
    .AMT_W(AMT_W), .TUBE_W(TUBE_W), .TUBE_MAX(TUBE_MAX),
    .INIT_CNT(INIT_CNT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .hrst_n(hrst_n), .bus(bus)
  );

  typedef struct { logic [1:0] code; bit jam; } coin_t;
  typedef struct { int sf; bit se; bit je; int q; int d; int n; } res_t;

  coin_t coinq[$];
  res_t  resq[$];
  int total = 0, bad = 0;
  int mcnt[4];                      // model tube counts, index = coin code
  int cval[4] = '{0, 5, 10, 25};
  int jam_at = -1;
  int cidx = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Greedy payout from the rules: largest coin that fits and is in stock.
  function automatic int predict(int bal, int jam);
    int rem = bal, k = 0, c;
    res_t r;
    coin_t ce;
    r.je = 1'b0;
    forever begin
      c = 0;
      for (int i = 3; i >= 1; i--)
        if (c == 0 && rem >= cval[i] && mcnt[i] > 0) c = i;
      if (c == 0) break;
      ce.code = 2'(c);
      ce.jam  = (k == jam);
      coinq.push_back(ce);
      k++;
      if (ce.jam) begin r.je = 1'b1; break; end
      mcnt[c]--;
      rem -= cval[c];
    end
    r.sf = rem; r.se = (rem != 0);
    r.n = mcnt[1]; r.d = mcnt[2]; r.q = mcnt[3];
    resq.push_back(r);
    return k;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin tick(); n++; end
    chk("idle_reached", bus.busy, 0);
  endtask

  task automatic chk_counts(string tag);
    chk({tag, "_n"}, bus.n_cnt, mcnt[1]);
    chk({tag, "_d"}, bus.d_cnt, mcnt[2]);
    chk({tag, "_q"}, bus.q_cnt, mcnt[3]);
  endtask

  task automatic do_refill(int c, int cnt);
    bit eo;
    int s;
    eo = 1'b0;
    wait_idle();
    if (c != 0) begin
      s = mcnt[c] + cnt;
      if (s > TUBE_MAX) begin mcnt[c] = TUBE_MAX; eo = 1'b1; end
      else mcnt[c] = s;
    end
    bus.refill_valid = 1'b1; bus.refill_coin = 2'(c); bus.refill_count = TUBE_W'(cnt);
    tick();
    bus.refill_valid = 1'b0;
    chk("refill_ovf", bus.refill_ovf, eo);
    chk_counts("refill_cnt");
  endtask

  task automatic run_txn(int bal, int jam, bit injr, int rc, int rn, bit injs);
    int nexp, n;
    wait_idle();
    nexp = predict(bal, jam);
    jam_at = jam;
    cidx = 0;
    bus.balance = AMT_W'(bal);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("cv_after_start", bus.coin_valid, 0);
    if (injr) begin
      bus.refill_valid = 1'b1; bus.refill_coin = 2'(rc); bus.refill_count = TUBE_W'(rn);
    end
    if (injs) begin
      bus.start = 1'b1; bus.balance = AMT_W'($urandom_range(1, 300));
    end
    tick();
    bus.refill_valid = 1'b0;
    bus.start = 1'b0;
    if (nexp > 0) chk("first_coin_latency", bus.coin_valid, 1);
    else          chk("no_coin_done_latency", bus.done, 1);
    if (injr) chk("refill_busy_ovf", bus.refill_ovf, 0);
    n = 0;
    while (bus.busy && n < 500) begin tick(); n++; end
    chk("txn_complete", bus.busy, 0);
  endtask

  // Coin mechanism: acks after 0..3 cycles, never acks the planned jam coin.
  initial begin
    int my, d, n;
    bus.coin_ack = 1'b0;
    forever begin
      tick();
      if (hrst_n && bus.coin_valid) begin
        my = cidx;
        cidx++;
        if (my == jam_at) begin
          n = 0;
          while (bus.coin_valid && n < 20) begin tick(); n++; end
        end else begin
          d = $urandom_range(0, 3);
          repeat (d) tick();
          if (hrst_n) begin
            bus.coin_ack = 1'b1;
            tick();
            bus.coin_ack = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares presented coins and payout results against the queues.
  initial begin
    bit prev_cv = 1'b0;
    int vlen = 0;
    coin_t cur;
    res_t r;
    cur.code = 2'b00; cur.jam = 1'b0;
    forever begin
      @(negedge clk);
      if (!hrst_n) begin prev_cv = 1'b0; continue; end
      if (bus.coin_valid) begin
        if (!prev_cv) begin
          chk("coin_expected", int'(coinq.size() != 0), 1);
          if (coinq.size() != 0) cur = coinq.pop_front();
          vlen = 0;
        end
        vlen++;
        chk("coin_code", bus.coin_code, cur.code);
      end else if (prev_cv && cur.jam) begin
        chk("jam_valid_cycles", vlen, ACK_TIMEOUT);
      end
      prev_cv = bus.coin_valid;
      if (bus.done) begin
        chk("done_expected", int'(resq.size() != 0), 1);
        if (resq.size() != 0) begin
          r = resq.pop_front();
          chk("shortfall", bus.shortfall, r.sf);
          chk("short_err", bus.short_err, r.se);
          chk("jam_err", bus.jam_err, r.je);
          chk("done_q_cnt", bus.q_cnt, r.q);
          chk("done_d_cnt", bus.d_cnt, r.d);
          chk("done_n_cnt", bus.n_cnt, r.n);
        end
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_coin_valid"}, bus.coin_valid, 0);
    chk({tag, "_coin_code"}, bus.coin_code, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_shortfall"}, bus.shortfall, 0);
    chk({tag, "_short_err"}, bus.short_err, 0);
    chk({tag, "_jam_err"}, bus.jam_err, 0);
    chk({tag, "_refill_ovf"}, bus.refill_ovf, 0);
    chk({tag, "_n"}, bus.n_cnt, INIT_CNT);
    chk({tag, "_d"}, bus.d_cnt, INIT_CNT);
    chk({tag, "_q"}, bus.q_cnt, INIT_CNT);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, j;
    bus.start = 1'b0; bus.balance = '0;
    bus.refill_valid = 1'b0; bus.refill_coin = 2'b00; bus.refill_count = '0;
    for (int i = 1; i <= 3; i++) mcnt[i] = INIT_CNT;
    hrst_n = 1'b1;
    #1 hrst_n = 1'b0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) tick();
    hrst_n = 1'b1;
    tick();

    run_txn(40, -1, 0, 0, 0, 0);          // Q, D, N; all tubes to 9
    chk_counts("t1");
    run_txn(0, -1, 0, 0, 0, 0);           // no coins, done after 2 cycles
    run_txn(225, -1, 0, 0, 0, 0);         // drains quarters
    run_txn(80, -1, 0, 0, 0, 0);          // leaves one dime
    run_txn(30, -1, 0, 0, 0, 0);          // dime then nickels
    run_txn(23, -1, 0, 0, 0, 0);          // remainder 3 is a shortfall
    run_txn(200, -1, 0, 0, 0, 0);         // tubes short: large shortfall
    chk_counts("after_drain");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_refill($urandom_range(0, 3), $urandom_range(0, 63));
      b = $urandom_range(0, 200);
      j = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      run_txn(b, j, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 63), 1'($urandom_range(0, 1)));
    end

    do_refill(3, 10);
    run_txn(25, 0, 0, 0, 0, 0);           // jam on the first coin
    chk_counts("after_jam");

    // Reset in the middle of a payout: abort, no done pulse, tubes reloaded.
    wait_idle();
    void'(predict(100, -1));
    jam_at = -1;
    cidx = 0;
    bus.balance = AMT_W'(100);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    hrst_n = 1'b0;
    #1;
    coinq.delete();
    resq.delete();
    for (int i = 1; i <= 3; i++) mcnt[i] = INIT_CNT;
    chk_reset_outputs("midreset");
    repeat (5) tick();
    hrst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_busy", bus.busy, 0);

    do_refill(3, 45);                     // 10 + 45 clips at 50
    run_txn(40, -1, 1, 2, 5, 0);          // dime refill while busy is dropped
    chk_counts("t6");

    repeat (5) tick();
    chk("queues_drained", coinq.size() + resq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
